sad_reduce_stage: RTL and testbench

- Parametrised successor to the fixed 16-to-4 SAD adder/pipeline-register stage.
- Reduces N_IN absolute-difference lanes to N_OUT partial sums and registers them.
- Adds a valid/ready stall handshake, saturation, and a multi-beat accumulate mode for SAD over several block rows.
- Carries an opaque control sideband (SAD, RegWrite, MemToReg, Hi/Lo, etc.) through with the data.

---
 rtl/sad_reduce_stage.sv | 153 +++++++++++++++
 tb/tb_sad_reduce_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sad_reduce_stage.sv
// SAD reduction stage: folds N_IN absolute-difference lanes into N_OUT saturating
// partial sums, with a valid/ready output register and a multi-beat accumulate mode.
module sad_reduce_stage #(
  parameter int DATA_W = 32,
  parameter int N_IN   = 16,
  parameter int N_OUT  = 4,
  parameter int SIDE_W = 256
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_IN*DATA_W-1:0]  in_lanes,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic [SIDE_W-1:0]       in_side,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_OUT*DATA_W-1:0] out_lanes,
  output logic [SIDE_W-1:0]       out_side,
  output logic                    out_sat,
  output logic                    out_drop
);

  localparam int G     = N_IN / N_OUT;
  localparam int SUM_W = DATA_W + $clog2(G) + 1;

  if (N_OUT < 1) begin : g_bad_out
    $error("sad_reduce_stage: N_OUT must be >= 1");
  end else if ((N_IN % N_OUT) != 0) begin : g_bad_ratio
    $error("sad_reduce_stage: N_IN must be a multiple of N_OUT");
  end

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                    state, state_n;
  logic                      mode_q, mode_n;
  logic [N_OUT*DATA_W-1:0]   acc;
  logic                      acc_sat;

  logic [N_OUT*DATA_W-1:0]   grp_sum, add_sum;
  logic [N_OUT-1:0]          grp_sat, add_sat;

  logic accept;
  logic out_load, out_from_acc, acc_load, acc_add, drop;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Full-width sum then clamp: equivalent to clamping at every adder since all terms are unsigned.
  for (genvar j = 0; j < N_OUT; j++) begin : g_grp
    logic [SUM_W-1:0]  tot;
    logic [DATA_W:0]   acc_tot;

    always_comb begin
      tot = '0;
      for (int unsigned i = 0; i < G; i++)
        tot = tot + SUM_W'(in_lanes[(j*G+i)*DATA_W +: DATA_W]);
    end

    assign grp_sat[j] = |tot[SUM_W-1:DATA_W];
    assign grp_sum[j*DATA_W +: DATA_W] = grp_sat[j] ? '1 : tot[DATA_W-1:0];

    assign acc_tot    = {1'b0, acc[j*DATA_W +: DATA_W]} + {1'b0, grp_sum[j*DATA_W +: DATA_W]};
    assign add_sat[j] = acc_tot[DATA_W];
    assign add_sum[j*DATA_W +: DATA_W] = add_sat[j] ? '1 : acc_tot[DATA_W-1:0];
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state  <= IDLE;
      mode_q <= 1'b0;
    end else begin
      state  <= state_n;
      mode_q <= mode_n;
    end
  end

  always_comb begin
    state_n      = state;
    mode_n       = mode_q;
    out_load     = 1'b0;
    out_from_acc = 1'b0;
    acc_load     = 1'b0;
    acc_add      = 1'b0;
    drop         = 1'b0;
    if (accept) begin
      unique case (state)
        IDLE: begin
          // A beat without in_first in IDLE still opens a frame.
          if (!mode || in_last) begin
            out_load = 1'b1;
          end else begin
            acc_load = 1'b1;
            mode_n   = mode;
            state_n  = ACCUM;
          end
        end
        ACCUM: begin
          if (!mode_q) begin
            out_load = 1'b1;
            state_n  = IDLE;
          end else if (in_first) begin
            drop = 1'b1;
            if (in_last) begin
              out_load = 1'b1;
              state_n  = IDLE;
            end else begin
              acc_load = 1'b1;
            end
          end else if (in_last) begin
            out_from_acc = 1'b1;
            state_n      = IDLE;
          end else begin
            acc_add = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      out_valid <= 1'b0;
      out_lanes <= '0;
      out_side  <= '0;
      out_sat   <= 1'b0;
      out_drop  <= 1'b0;
      acc       <= '0;
      acc_sat   <= 1'b0;
    end else begin
      out_drop <= drop;
      if (out_load || out_from_acc) begin
        out_valid <= 1'b1;
        out_lanes <= out_load ? grp_sum : add_sum;
        out_sat   <= out_load ? |grp_sat : (acc_sat || |grp_sat || |add_sat);
        out_side  <= in_side;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (acc_load) begin
        acc     <= grp_sum;
        acc_sat <= |grp_sat;
      end else if (acc_add) begin
        acc     <= add_sum;
        acc_sat <= acc_sat || |grp_sat || |add_sat;
      end
    end
  end

endmodule

// File: tb/tb_sad_reduce_stage.sv
// Directed bench for sad_reduce_stage: a default-width instance for reduce, backpressure,
// accumulate, restart and reset, plus an 8-bit instance for saturation boundaries.
module tb_sad_reduce_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic Reset;

  // default-parameter instance
  logic         mode, in_valid, in_ready, in_first, in_last;
  logic [511:0] in_lanes;
  logic [255:0] in_side, out_side;
  logic         out_valid, out_ready, out_sat, out_drop;
  logic [127:0] out_lanes;

  // 8-bit instance
  logic         mode8, in_valid8, in_ready8, in_first8, in_last8;
  logic [127:0] in_lanes8;
  logic [7:0]   in_side8, out_side8;
  logic         out_valid8, out_ready8, out_sat8, out_drop8;
  logic [31:0]  out_lanes8;

  int checks = 0;
  int errors = 0;

  sad_reduce_stage dut (
    .Clk(clk), .Reset(Reset), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_lanes(in_lanes), .in_first(in_first), .in_last(in_last), .in_side(in_side),
    .out_valid(out_valid), .out_ready(out_ready), .out_lanes(out_lanes),
    .out_side(out_side), .out_sat(out_sat), .out_drop(out_drop)
  );

  sad_reduce_stage #(.DATA_W(8), .N_IN(16), .N_OUT(4), .SIDE_W(8)) dut8 (
    .Clk(clk), .Reset(Reset), .mode(mode8), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_lanes(in_lanes8), .in_first(in_first8), .in_last(in_last8), .in_side(in_side8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_lanes(out_lanes8),
    .out_side(out_side8), .out_sat(out_sat8), .out_drop(out_drop8)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [511:0] fill(input logic [31:0] v);
    return {16{v}};
  endfunction

  initial begin
    logic [511:0] ramp;
    Reset = 1'b0;
    mode = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    in_lanes = '0; in_side = '0; out_ready = 1'b1;
    mode8 = 1'b0; in_valid8 = 1'b0; in_first8 = 1'b0; in_last8 = 1'b0;
    in_lanes8 = '0; in_side8 = '0; out_ready8 = 1'b1;
    repeat (3) step();
    chk("rst_valid", 256'(out_valid), 256'(0));
    chk("rst_lanes", 256'(out_lanes), 256'(0));
    chk("rst_sat",   256'(out_sat),   256'(0));
    Reset = 1'b1;
    step();
    chk("rst_in_ready", 256'(in_ready), 256'(1));

    // 1: reduce, lanes 1..16
    for (int k = 0; k < 16; k++) ramp[k*32 +: 32] = 32'(k + 1);
    in_lanes = ramp; in_side = 256'hA5A5_0001; in_valid = 1'b1;
    step();
    chk("t1_valid", 256'(out_valid), 256'(1));
    chk("t1_lanes", 256'(out_lanes), 256'({32'd58, 32'd42, 32'd26, 32'd10}));
    chk("t1_sat",   256'(out_sat),   256'(0));
    chk("t1_side",  out_side, 256'hA5A5_0001);
    in_valid = 1'b0;
    step();
    chk("t1_drain", 256'(out_valid), 256'(0));

    // 3: backpressure, three beats
    out_ready = 1'b0;
    in_lanes = fill(32'd1); in_side = 256'd1; in_valid = 1'b1;
    step();
    in_lanes = fill(32'd2); in_side = 256'd2;
    step();
    step();
    chk("t3_hold_valid", 256'(out_valid), 256'(1));
    chk("t3_hold_lanes", 256'(out_lanes), 256'({4{32'd4}}));
    chk("t3_hold_side",  out_side, 256'd1);
    chk("t3_in_ready",   256'(in_ready), 256'(0));
    out_ready = 1'b1;
    step();
    chk("t3_b_lanes", 256'(out_lanes), 256'({4{32'd8}}));
    chk("t3_b_side",  out_side, 256'd2);
    in_lanes = fill(32'd3); in_side = 256'd3;
    step();
    chk("t3_c_lanes", 256'(out_lanes), 256'({4{32'd12}}));
    chk("t3_c_side",  out_side, 256'd3);
    in_valid = 1'b0;
    step();
    chk("t3_drain", 256'(out_valid), 256'(0));

    // 4: accumulate 4 beats; mode flipped mid-frame must be ignored
    mode = 1'b1; in_lanes = fill(32'd1); in_valid = 1'b1;
    in_first = 1'b1; in_last = 1'b0; in_side = 256'd11;
    step();
    chk("t4_b1_novalid", 256'(out_valid), 256'(0));
    in_first = 1'b0; in_side = 256'd12;
    step();
    chk("t4_b2_novalid", 256'(out_valid), 256'(0));
    in_side = 256'd13;
    step();
    chk("t4_b3_novalid", 256'(out_valid), 256'(0));
    in_last = 1'b1; in_side = 256'd44; mode = 1'b0;
    step();
    chk("t4_valid", 256'(out_valid), 256'(1));
    chk("t4_lanes", 256'(out_lanes), 256'({4{32'd16}}));
    chk("t4_side",  out_side, 256'd44);
    chk("t4_sat",   256'(out_sat), 256'(0));
    in_valid = 1'b0; in_last = 1'b0;
    step();

    // 5: restart mid-frame
    mode = 1'b1; in_valid = 1'b1; in_lanes = fill(32'd1); in_first = 1'b1;
    step();
    in_first = 1'b0;
    step();
    chk("t5_mid_drop", 256'(out_drop), 256'(0));
    in_lanes = fill(32'd2); in_first = 1'b1; in_last = 1'b1;
    step();
    chk("t5_drop",  256'(out_drop), 256'(1));
    chk("t5_valid", 256'(out_valid), 256'(1));
    chk("t5_lanes", 256'(out_lanes), 256'({4{32'd8}}));
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    step();
    chk("t5_drop_end", 256'(out_drop), 256'(0));

    // 6: reset mid-frame
    in_valid = 1'b1; in_lanes = fill(32'd1); in_first = 1'b1;
    step();
    in_first = 1'b0;
    step();
    in_valid = 1'b0; Reset = 1'b0;
    step();
    chk("t6_rst_valid", 256'(out_valid), 256'(0));
    chk("t6_rst_lanes", 256'(out_lanes), 256'(0));
    chk("t6_rst_drop",  256'(out_drop),  256'(0));
    Reset = 1'b1;
    step();
    chk("t6_in_ready", 256'(in_ready), 256'(1));
    in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1; in_side = 256'd66;
    step();
    chk("t6_valid", 256'(out_valid), 256'(1));
    chk("t6_lanes", 256'(out_lanes), 256'({4{32'd4}}));
    chk("t6_drop",  256'(out_drop),  256'(0));
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; mode = 1'b0;
    step();

    // 2: saturation on the 8-bit instance
    in_lanes8 = '0; in_lanes8[31:0] = 32'h8080_8080; in_side8 = 8'h5A; in_valid8 = 1'b1;
    step();
    chk("t2_lanes", 256'(out_lanes8), 256'(32'h0000_00FF));
    chk("t2_sat",   256'(out_sat8),   256'(1));
    chk("t2_side",  256'(out_side8),  256'(8'h5A));
    in_lanes8[31:0] = 32'h0000_807F;
    step();
    chk("t2_edge_lanes", 256'(out_lanes8), 256'(32'h0000_00FF));
    chk("t2_edge_sat",   256'(out_sat8),   256'(0));
    // accumulator clamp: 0x80 + 0x80 per frame on lane 0
    mode8 = 1'b1; in_first8 = 1'b1; in_last8 = 1'b0; in_lanes8[31:0] = 32'h2020_2020;
    step();
    chk("t2_acc_novalid", 256'(out_valid8), 256'(0));
    in_first8 = 1'b0; in_last8 = 1'b1;
    step();
    chk("t2_acc_lanes", 256'(out_lanes8), 256'(32'h0000_00FF));
    chk("t2_acc_sat",   256'(out_sat8),   256'(1));
    in_valid8 = 1'b0; in_last8 = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
